// File: rtl/reg_bank_ctrl.sv
// Command sequencer for reg_bank: runs WRITE/READ/MOVE commands and returns read results.
// Define REG_BANK_CTRL_CLR_EN to build CLR_ALL (op 11); otherwise op 11 pulses cmd_err.
module reg_bank_ctrl #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srcA,
  input  logic [AW-1:0] cmd_srcB,
  input  logic [1:0]    cmd_en,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dataA,
  output logic [DW-1:0] rsp_dataB,
  output logic          cmd_err,
  output logic          bank_regwen,
  output logic [AW-1:0] bank_selwreg,
  output logic [1:0]    bank_endreg,
  output logic [DW-1:0] bank_inA,
  output logic [AW-1:0] bank_seloutA,
  output logic [AW-1:0] bank_seloutB,
  output logic          bank_cnstA,
  output logic          bank_cnstB,
  output logic          bank_enrregA,
  output logic          bank_enrregB,
  input  logic [DW-1:0] bank_outA,
  input  logic [DW-1:0] bank_outB
);

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_MOVE  = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

`ifdef REG_BANK_CTRL_CLR_EN
  typedef enum logic [2:0] {IDLE, EXEC, RSP, MOVE_WR, CLR} state_e;
`else
  typedef enum logic [2:0] {IDLE, EXEC, RSP, MOVE_WR} state_e;
`endif

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] srca_q, srca_d;
  logic [AW-1:0] srcb_q, srcb_d;
  logic [1:0]    en_q, en_d;
  logic [DW-1:0] data_q, data_d;
`ifdef REG_BANK_CTRL_CLR_EN
  logic [AW-1:0] cnt_q, cnt_d;
`endif

  logic cmd_fire;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_valid = (state_q == RSP);
  // bank outputs only change while enrreg is high, which never happens in RSP
  assign rsp_dataA = bank_outA;
  assign rsp_dataB = bank_outB;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    en_d    = en_q;
    data_d  = data_q;
`ifdef REG_BANK_CTRL_CLR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          op_d    = op_e'(cmd_op);
          dst_d   = cmd_dst;
          srca_d  = cmd_srcA;
          srcb_d  = cmd_srcB;
          en_d    = cmd_en;
          data_d  = cmd_data;
          state_d = EXEC;
`ifdef REG_BANK_CTRL_CLR_EN
          if (op_e'(cmd_op) == OP_CLR) begin
            state_d = CLR;
            cnt_d   = '0;
          end
`endif
        end
      end
      EXEC: begin
        case (op_q)
          OP_READ: state_d = RSP;
          OP_MOVE: state_d = MOVE_WR;
          default: state_d = IDLE;
        endcase
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      MOVE_WR: state_d = IDLE;
`ifdef REG_BANK_CTRL_CLR_EN
      CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_regwen  = 1'b0;
    bank_selwreg = '0;
    bank_endreg  = '0;
    bank_inA     = '0;
    bank_seloutA = '0;
    bank_seloutB = '0;
    bank_cnstA   = 1'b0;
    bank_cnstB   = 1'b0;
    bank_enrregA = 1'b0;
    bank_enrregB = 1'b0;
    cmd_err      = 1'b0;
    case (state_q)
      EXEC: begin
        case (op_q)
          OP_WRITE: begin
            bank_regwen  = 1'b1;
            bank_selwreg = dst_q;
            bank_endreg  = en_q;
            bank_inA     = data_q;
          end
          OP_READ: begin
            bank_enrregA = 1'b1;
            bank_enrregB = 1'b1;
            bank_seloutA = srca_q;
            bank_seloutB = srcb_q;
            bank_cnstA   = en_q[1];
            bank_cnstB   = en_q[0];
          end
          OP_MOVE: begin
            bank_enrregA = 1'b1;
            bank_seloutA = srca_q;
          end
          OP_CLR: begin
`ifndef REG_BANK_CTRL_CLR_EN
            cmd_err = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      MOVE_WR: begin
        bank_regwen  = 1'b1;
        bank_selwreg = dst_q;
        bank_endreg  = en_q;
        bank_inA     = bank_outA;
      end
`ifdef REG_BANK_CTRL_CLR_EN
      CLR: begin
        bank_regwen  = 1'b1;
        bank_selwreg = cnt_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_WRITE;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      en_q    <= '0;
      data_q  <= '0;
`ifdef REG_BANK_CTRL_CLR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      en_q    <= en_d;
      data_q  <= data_d;
`ifdef REG_BANK_CTRL_CLR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Command sequencer that owns the control port of `reg_bank`: it accepts one command at a time over a valid/ready handshake and translates it into correctly timed `regwen`/`selwreg`/`endreg`/`inA` and `seloutA/B`/`cnstA/B`/`enrregA/B` activity. It returns read results over a second valid/ready handshake and supports register-to-register moves and a whole-bank clear. It sits between the Project3 top-level command source and `reg_bank`, on the same clock.

## Interface
- `DW`, 64: data width; must equal the `reg_bank` word width.
- `AW`, 4: register index width; the bank holds 2**AW = 16 registers.
- `clock` in 1: master clock, posedge active.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 2: operation code. 00 WRITE, 01 READ, 10 MOVE, 11 CLR_ALL.
- `cmd_dst` in AW: destination register (WRITE, MOVE).
- `cmd_srcA` in AW: source register for outA (READ, MOVE).
- `cmd_srcB` in AW: source register for outB (READ).
- `cmd_en` in 2: endreg code for WRITE/MOVE; for READ, bit1 = cnstA and bit0 = cnstB.
- `cmd_data` in DW: write data (WRITE).
- `rsp_valid` out 1: read result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_dataA` out DW: read result A, equal to `bank_outA`.
- `rsp_dataB` out DW: read result B, equal to `bank_outB`.
- `cmd_err` out 1: one-cycle pulse when an unsupported op is discarded.
- `bank_regwen` out 1, `bank_selwreg` out AW, `bank_endreg` out 2, `bank_inA` out DW: bank write port.
- `bank_seloutA` out AW, `bank_seloutB` out AW, `bank_cnstA` out 1, `bank_cnstB` out 1, `bank_enrregA` out 1, `bank_enrregB` out 1: bank read port.
- `bank_outA` in DW, `bank_outB` in DW: registered bank outputs.

## Operation
- **States:** IDLE, EXEC, RSP, MOVE_WR, CLR.
- **Command register:** captures op, dst, srcA, srcB, en and data on acceptance (`cmd_valid & cmd_ready`).
- **Output decode:** bank controls are decoded combinationally from the state and the command register. In every state not listed below, all bank controls are 0.
- **IDLE:** `cmd_ready` = 1.
  - On acceptance, go to EXEC.
  - Exception: op 11 with CLR enabled goes to CLR with counter = 0.
- **EXEC, WRITE:**
  - Drive `regwen`=1, `selwreg`=dst, `endreg`=en, `inA`=data.
  - Next state is IDLE.
- **EXEC, READ:**
  - Drive `enrregA`=`enrregB`=1, `seloutA`=srcA, `seloutB`=srcB, `cnstA`=en[1], `cnstB`=en[0].
  - Next state is RSP.
- **EXEC, MOVE:**
  - Drive `enrregA`=1, `seloutA`=srcA, `cnstA`=0.
  - Next state is MOVE_WR.
- **RSP:**
  - `rsp_valid`=1 and all bank enables are 0, so `bank_outA/B` hold steady.
  - Stay in RSP until `rsp_ready`=1, then go to IDLE.
- **MOVE_WR:**
  - Drive `regwen`=1, `selwreg`=dst, `endreg`=en, `inA`=`bank_outA`.
  - Next state is IDLE.
- **CLR:**
  - Drive `regwen`=1, `selwreg`=counter, `endreg`=00, `inA`=0.
  - The counter increments each cycle; at 15 it wraps to 0 and the state goes to IDLE.
- **Source equals destination on MOVE:** legal, and the register is rewritten with its own value.

## Timing
- **Reset values:** `reset_n` low forces state IDLE, counter 0 and the command register 0, immediately and asynchronously. As a result `cmd_ready`=1, while `rsp_valid`, `cmd_err` and all bank controls are 0. A reset asserted mid-operation aborts the command; partial CLR writes remain in the bank.
- **Timeline:** acceptance at cycle T; bank controls active in T+1.
- **WRITE:** the bank is written at the end of T+1; `cmd_ready` is high again in T+2, giving a throughput of 1 write per 2 cycles.
- **READ:** `rsp_valid` rises in T+2. The minimum turnaround is 3 cycles when `rsp_ready` is held high.
- **MOVE:** the write occurs in T+2; `cmd_ready` is high in T+3.
- **CLR_ALL:** writes occur in T+1..T+16; `cmd_ready` is high in T+17.
- **Handshake rule:** `rsp_valid` never drops without `rsp_ready`, and `rsp_data*` is stable while `rsp_valid`=1.

## Configuration
- **`REG_BANK_CTRL_CLR_EN` defined:** op 11 runs CLR_ALL as described, and `cmd_err` stays 0.
- **`REG_BANK_CTRL_CLR_EN` undefined:**
  - The counter and the CLR state are not built.
  - Op 11 is accepted, goes to EXEC with no bank activity, and pulses `cmd_err` in T+1.
  - The state then returns to IDLE.

## Test plan
- **Reset check:** assert `reset_n`=0 mid-READ (during RSP) -> `rsp_valid` and all bank controls are 0 at once; `cmd_ready`=1 after release.
- **Write then read:** WRITE dst=3, data=64'h0123_4567_89AB_CDEF, en=00; then READ srcA=3, srcB=0, en=00 -> `rsp_valid` in T+2 with `rsp_dataA`=64'h0123_4567_89AB_CDEF and `rsp_dataB`=0.
- **Response back-pressure:** READ with `rsp_ready` held 0 for 5 cycles -> `rsp_valid` stays 1, data is unchanged, and `cmd_ready`=0 throughout.
- **Move:** WRITE r5=64'hDEAD; MOVE srcA=5 dst=9 en=00; READ srcA=9 -> `rsp_dataA`=64'hDEAD, and the bank write occurs exactly at T+2 of the MOVE.
- **Clear all (macro defined):** fill r0..r15 with nonzero values; CLR_ALL -> 16 consecutive writes with `selwreg` 0..15, `cmd_ready` low for 16 cycles, and every READ afterwards returns 0.
- **Unsupported op (macro undefined):** op 11 -> one `cmd_err` pulse, no `regwen`, and bank contents unchanged.
